mdu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage. It owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo. It drives the `busy` signal that the stall unit uses to hold mult/div/mfhi/mflo/mthi/mtlo instructions in ID. The stall unit covers the start cycle itself, because the instruction is then in EX. This block covers every following cycle until the result is written.

---
 rtl/mdu.sv | 128 ++++++++++++
 tb/tb_mdu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// ============================================================================
// mdu : multi-cycle multiply/divide unit owning the HI/LO registers
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  mdu_op_i,
  input  logic        req_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_tmp_q, hi_tmp_d;
  logic [31:0]      lo_tmp_q, lo_tmp_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             accept;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      div_b;
  logic [31:0]      quot_s, rem_s, quot_u, rem_u;

  assign accept = start_i && !req_i && !busy_o && (mdu_op_i != 3'd0);

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Substitute a divisor of one on zero so the dividers never produce X;
  // the dz flag suppresses the commit anyway.
  assign div_b  = (b_i == 32'd0) ? 32'd1 : b_i;
  assign quot_s = $signed(a_i) / $signed(div_b);
  assign rem_s  = $signed(a_i) % $signed(div_b);
  assign quot_u = a_i / div_b;
  assign rem_u  = a_i % div_b;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if ((cnt_q == CNT_W'(1)) && !dz_q) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end else if (accept) begin
      case (mdu_op_i)
        OP_MULT: begin
          {hi_tmp_d, lo_tmp_d} = prod_s;
          dz_d  = 1'b0;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {hi_tmp_d, lo_tmp_d} = prod_u;
          dz_d  = 1'b0;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        OP_DIV: begin
          hi_tmp_d = rem_s;
          lo_tmp_d = quot_s;
          dz_d     = (b_i == 32'd0);
          cnt_d    = CNT_W'(DIV_CYCLES);
        end
        OP_DIVU: begin
          hi_tmp_d = rem_u;
          lo_tmp_d = quot_u;
          dz_d     = (b_i == 32'd0);
          cnt_d    = CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = a_i;
        OP_MTLO: lo_d = a_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o = (cnt_q != '0);
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
// tb_mdu : directed scoreboard bench for the multiply/divide unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic        req;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .mdu_op_i (mdu_op),
    .req_i    (req),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    start  = 1'b1;
    mdu_op = op;
    a      = av;
    b      = bv;
    tick();
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  // Count busy cycles (bounded), optionally injecting an ignored div start on
  // busy cycle 2 and a flush on busy cycle 3, then compare against the scoreboard.
  task automatic wait_done(input string tag, input int n_exp, input bit inject);
    int cycles;
    logic [63:0] exp;
    cycles = 0;
    while (busy && cycles < 50) begin
      start  = inject && (cycles == 1);
      mdu_op = (inject && cycles == 1) ? 3'd3 : 3'd0;
      a      = (inject && cycles == 1) ? 32'd100 : a;
      b      = (inject && cycles == 1) ? 32'd7 : b;
      req    = inject && (cycles == 2);
      tick();
      cycles++;
    end
    start  = 1'b0;
    mdu_op = 3'd0;
    req    = 1'b0;
    check({tag, "_busy_cycles"}, 64'(cycles), 64'(n_exp));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_hilo"}, {hi, lo}, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; req = 1'b0; a = '0; b = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // multu 0xFFFFFFFF * 2
    sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    check("multu_busy_start", 64'(busy), 64'd1);
    wait_done("multu", 5, 1'b0);

    // div -7 / 2, issued on the edge right after busy fell
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 10, 1'b0);

    // divu 100 / 7
    sb_q.push_back({32'd2, 32'd14});
    issue(3'd4, 32'd100, 32'd7);
    wait_done("divu", 10, 1'b0);

    // mtlo / mthi then divu by zero
    issue(3'd6, 32'h0000_1234, 32'd0);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_lo", 64'(lo), 64'h1234);
    issue(3'd5, 32'h0000_5678, 32'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h5678);
    sb_q.push_back({32'h0000_5678, 32'h0000_1234});
    issue(3'd4, 32'd99, 32'd0);
    wait_done("divu_zero", 10, 1'b0);

    // mult 3 * -4 with an ignored start and a flush while busy
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF4});
    issue(3'd1, 32'd3, 32'hFFFF_FFFC);
    wait_done("mult_ignored", 5, 1'b1);
    tick();
    tick();
    check("ignored_div_never_runs", 64'(busy), 64'd0);
    check("ignored_hilo_kept", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF4});

    // start with req high is flushed
    req = 1'b1;
    issue(3'd1, 32'd5, 32'd5);
    req = 1'b0;
    check("flushed_busy", 64'(busy), 64'd0);
    tick();
    check("flushed_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF4});

    // reserved op is treated as none
    issue(3'd7, 32'd1, 32'd1);
    check("reserved_busy", 64'(busy), 64'd0);

    // multu 0xFFFFFFFF squared
    sb_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 5, 1'b0);

    // reset on cycle 4 of a div
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    check("midreset_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    repeat (12) tick();
    check("midreset_no_late_write", {hi, lo}, 64'd0);
    check("midreset_busy_after", 64'(busy), 64'd0);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
